pe_stream_loader: RTL and testbench

Sequencer that streams ifmap and filter words from a single-port SRAM into the PE's ifmap and filter circular buffers. Arbitrates the one read port between the two streams, tags ifmap words with the start/end bits the PE consumes (`{start, end, data}`), and back-pressures on buffer full. Sits between the global buffer SRAM and the PE input buffers; one pass per `start` pulse.

---
 rtl/pe_stream_loader_pkg.sv | 21 ++
 rtl/pe_stream_loader_rr_arbiter2.sv | 40 ++++
 rtl/pe_stream_loader.sv | 173 +++++++++++++++++
 tb/tb_pe_stream_loader.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_stream_loader_pkg.sv
// pe_pkg: shared types and constants for the PE stream loader.
//   state_t : sequencer states (IDLE, LOAD, DRAIN, DONE)
//   sel_t   : which stream owns a read (SEL_IFMAP, SEL_FILTER)
//   TAG_WIDTH : width of the {start, end} tag prepended to ifmap words
package pe_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    SEL_IFMAP  = 1'b0,
    SEL_FILTER = 1'b1
  } sel_t;

  localparam int TAG_WIDTH = 2;

endpackage

// File: rtl/pe_stream_loader_rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin arbiter.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clear        : restart arbitration so ifmap wins the next tie
//   i_req[0]/[1]   : ifmap / filter request
//   o_grant        : one-hot grant (combinational from requests)
// The last-granted pointer is registered; on a tie the stream that did
// not win last time is granted.
module rr_arbiter2
  import pe_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clear,
  input  logic [1:0] i_req,
  output logic [1:0] o_grant
);

  sel_t r_last;

  always_comb begin
    o_grant = i_req;
    if (&i_req) begin
      o_grant = (r_last == SEL_FILTER) ? 2'b01 : 2'b10;
    end
  end

  // Pointer starts at "filter went last" so ifmap takes the first tie.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last <= SEL_FILTER;
    end else if (i_clear) begin
      r_last <= SEL_FILTER;
    end else if (o_grant[1]) begin
      r_last <= SEL_FILTER;
    end else if (o_grant[0]) begin
      r_last <= SEL_IFMAP;
    end
  end

endmodule

// File: rtl/pe_stream_loader.sv
// pe_stream_loader: streams ifmap and filter words from a single-port SRAM
// into the PE ifmap/filter buffers, one pass per i_start pulse.
//   i_start, i_*_base, i_*_len : pass configuration, latched on start in IDLE
//   o_mem_rd_en, o_mem_addr    : SRAM read request
//   i_mem_rdata                : read data, valid the cycle after o_mem_rd_en
//   i_ifmap_full, i_filter_full: buffer full flags (checked at issue only)
//   o_ifmap_wr_en/o_ifmap_wdata: ifmap write, {start_tag, end_tag, data}
//   o_filter_wr_en/o_filter_wdata: filter write
//   o_busy, o_done             : pass in progress / one-cycle completion pulse
module pe_stream_loader
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_ifmap_base,
  input  logic [LEN_WIDTH-1:0]  i_ifmap_len,
  input  logic [ADDR_WIDTH-1:0] i_filter_base,
  input  logic [LEN_WIDTH-1:0]  i_filter_len,
  output logic                  o_mem_rd_en,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  input  logic                  i_ifmap_full,
  input  logic                  i_filter_full,
  output logic                  o_ifmap_wr_en,
  output logic [DATA_WIDTH+1:0] o_ifmap_wdata,
  output logic                  o_filter_wr_en,
  output logic [DATA_WIDTH-1:0] o_filter_wdata,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  state_t                 r_state;
  logic [ADDR_WIDTH-1:0]  r_ifmap_base;
  logic [ADDR_WIDTH-1:0]  r_filter_base;
  logic [LEN_WIDTH-1:0]   r_ifmap_len;
  logic [LEN_WIDTH-1:0]   r_filter_len;
  logic [LEN_WIDTH-1:0]   r_ifmap_issued;
  logic [LEN_WIDTH-1:0]   r_filter_issued;
  logic                   r_mem_rd_en;
  logic [ADDR_WIDTH-1:0]  r_mem_addr;
  sel_t                   r_rd_sel;
  logic [TAG_WIDTH-1:0]   r_rd_tags;
  logic                   r_ret_valid;
  sel_t                   r_ret_sel;
  logic [TAG_WIDTH-1:0]   r_ret_tags;
  logic                   r_busy;
  logic                   r_done;

  logic       w_ifmap_left;
  logic       w_filter_left;
  logic       w_ifmap_req;
  logic       w_filter_req;
  logic       w_clear;
  logic       w_ifmap_wr;
  logic       w_filter_wr;
  logic [1:0] w_req;
  logic [1:0] w_grant;

  assign w_ifmap_left  = r_ifmap_issued < r_ifmap_len;
  assign w_filter_left = r_filter_issued < r_filter_len;

  // A read issued last cycle returns this cycle, so a stream with a read
  // registered in r_mem_rd_en still has a word in flight and must wait.
  assign w_ifmap_req  = (r_state == LOAD) && w_ifmap_left && !i_ifmap_full &&
                        !(r_mem_rd_en && (r_rd_sel == SEL_IFMAP));
  assign w_filter_req = (r_state == LOAD) && w_filter_left && !i_filter_full &&
                        !(r_mem_rd_en && (r_rd_sel == SEL_FILTER));
  assign w_req   = {w_filter_req, w_ifmap_req};
  assign w_clear = (r_state == IDLE) && i_start;

  rr_arbiter2 u_arb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (w_clear),
    .i_req   (w_req),
    .o_grant (w_grant)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= IDLE;
      r_ifmap_base    <= '0;
      r_filter_base   <= '0;
      r_ifmap_len     <= '0;
      r_filter_len    <= '0;
      r_ifmap_issued  <= '0;
      r_filter_issued <= '0;
      r_mem_rd_en     <= 1'b0;
      r_mem_addr      <= '0;
      r_rd_sel        <= SEL_IFMAP;
      r_rd_tags       <= '0;
      r_ret_valid     <= 1'b0;
      r_ret_sel       <= SEL_IFMAP;
      r_ret_tags      <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_mem_rd_en <= 1'b0;
      r_done      <= 1'b0;
      // Return path: the read tag follows the SRAM's one-cycle latency.
      r_ret_valid <= r_mem_rd_en;
      r_ret_sel   <= r_rd_sel;
      r_ret_tags  <= r_rd_tags;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_ifmap_base    <= i_ifmap_base;
            r_filter_base   <= i_filter_base;
            r_ifmap_len     <= i_ifmap_len;
            r_filter_len    <= i_filter_len;
            r_ifmap_issued  <= '0;
            r_filter_issued <= '0;
            r_busy          <= 1'b1;
            r_state         <= LOAD;
          end
        end
        LOAD: begin
          if (w_grant[0]) begin
            r_mem_rd_en    <= 1'b1;
            r_mem_addr     <= r_ifmap_base + ADDR_WIDTH'(r_ifmap_issued);
            r_rd_sel       <= SEL_IFMAP;
            r_rd_tags      <= {r_ifmap_issued == '0,
                               r_ifmap_issued == (r_ifmap_len - LEN_ONE)};
            r_ifmap_issued <= r_ifmap_issued + LEN_ONE;
          end else if (w_grant[1]) begin
            r_mem_rd_en     <= 1'b1;
            r_mem_addr      <= r_filter_base + ADDR_WIDTH'(r_filter_issued);
            r_rd_sel        <= SEL_FILTER;
            r_rd_tags       <= '0;
            r_filter_issued <= r_filter_issued + LEN_ONE;
          end
          if (!w_ifmap_left && !w_filter_left) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          // Any outstanding read is being written this cycle.
          if (!r_mem_rd_en) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign w_ifmap_wr  = r_ret_valid && (r_ret_sel == SEL_IFMAP);
  assign w_filter_wr = r_ret_valid && (r_ret_sel == SEL_FILTER);

  assign o_mem_rd_en    = r_mem_rd_en;
  assign o_mem_addr     = r_mem_addr;
  assign o_ifmap_wr_en  = w_ifmap_wr;
  assign o_ifmap_wdata  = w_ifmap_wr ? {r_ret_tags, i_mem_rdata} : '0;
  assign o_filter_wr_en = w_filter_wr;
  assign o_filter_wdata = w_filter_wr ? i_mem_rdata : '0;
  assign o_busy         = r_busy;
  assign o_done         = r_done;

endmodule

// File: tb/tb_pe_stream_loader.sv
module tb_pe_stream_loader;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] ifmap_base = '0;
  logic [LW-1:0] ifmap_len = '0;
  logic [AW-1:0] filter_base = '0;
  logic [LW-1:0] filter_len = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic          ifmap_full = 1'b0;
  logic          filter_full = 1'b0;
  logic          ifmap_wr_en;
  logic [DW+1:0] ifmap_wdata;
  logic          filter_wr_en;
  logic [DW-1:0] filter_wdata;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  pe_stream_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_ifmap_base   (ifmap_base),
    .i_ifmap_len    (ifmap_len),
    .i_filter_base  (filter_base),
    .i_filter_len   (filter_len),
    .o_mem_rd_en    (mem_rd_en),
    .o_mem_addr     (mem_addr),
    .i_mem_rdata    (mem_rdata),
    .i_ifmap_full   (ifmap_full),
    .i_filter_full  (filter_full),
    .o_ifmap_wr_en  (ifmap_wr_en),
    .o_ifmap_wdata  (ifmap_wdata),
    .o_filter_wr_en (filter_wr_en),
    .o_filter_wdata (filter_wdata),
    .o_busy         (busy),
    .o_done         (done)
  );

  // SRAM model: data appears the cycle after the read strobe, junk otherwise.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
    else           mem_rdata <= 16'($urandom);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model state: expected word/address streams per buffer.
  logic [DW+1:0] exp_if[$];
  logic [DW-1:0] exp_f[$];
  logic [AW-1:0] exp_ia[$];
  logic [AW-1:0] exp_fa[$];
  logic [DW+1:0] log_if[$];
  logic [DW-1:0] log_f[$];
  bit            log_sel[$];
  int  n_checks = 0;
  int  n_errors = 0;
  bit  m_active = 0;
  bit  m_busy = 0;
  bit  pass_done = 0;
  int  done_due = -1;
  int  start_cyc = 0;
  int  done_cyc = 0;
  int  rd_cnt = 0;
  bit  prev_rd = 0;
  logic [AW-1:0] prev_addr = '0;
  bit  iful_d1 = 0, iful_d2 = 0, fful_d1 = 0, fful_d2 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process: checks every DUT output against the model each cycle.
  always @(negedge clk) begin : cmp
    logic wrote;
    wrote = ifmap_wr_en | filter_wr_en;
    if (!rst_n) begin
      chk("reset_outputs", 32'({mem_rd_en, ifmap_wr_en, filter_wr_en, busy, done,
                                mem_addr != '0, ifmap_wdata != '0, filter_wdata != '0}), 32'd0);
      exp_if.delete(); exp_f.delete(); exp_ia.delete(); exp_fa.delete();
      m_active = 0; m_busy = 0; done_due = -1; prev_rd = 0;
      iful_d1 = 0; iful_d2 = 0; fful_d1 = 0; fful_d2 = 0;
    end else begin
      if (mem_rd_en) rd_cnt++;
      if (ifmap_wr_en) begin
        $display("cycle %0d ifmap write %05h", cyc, ifmap_wdata);
        chk("ifmap_write_latency", 32'(prev_rd), 32'd1);
        chk("ifmap_words_expected", 32'(exp_if.size() != 0), 32'd1);
        if (exp_if.size() != 0) begin
          chk("ifmap_wdata", 32'(ifmap_wdata), 32'(exp_if[0]));
          chk("ifmap_rd_addr", 32'(prev_addr), 32'(exp_ia[0]));
          chk("ifmap_full_at_issue", 32'(iful_d2), 32'd0);
          void'(exp_if.pop_front());
          void'(exp_ia.pop_front());
        end
        log_if.push_back(ifmap_wdata);
        log_sel.push_back(1'b0);
      end
      if (filter_wr_en) begin
        $display("cycle %0d filter write %04h", cyc, filter_wdata);
        chk("filter_write_latency", 32'(prev_rd), 32'd1);
        chk("filter_words_expected", 32'(exp_f.size() != 0), 32'd1);
        if (exp_f.size() != 0) begin
          chk("filter_wdata", 32'(filter_wdata), 32'(exp_f[0]));
          chk("filter_rd_addr", 32'(prev_addr), 32'(exp_fa[0]));
          chk("filter_full_at_issue", 32'(fful_d2), 32'd0);
          void'(exp_f.pop_front());
          void'(exp_fa.pop_front());
        end
        log_f.push_back(filter_wdata);
        log_sel.push_back(1'b1);
      end
      chk("single_write", 32'(ifmap_wr_en & filter_wr_en), 32'd0);
      if (prev_rd) chk("read_returned", 32'(wrote), 32'd1);
      if (m_active && wrote && exp_if.size() == 0 && exp_f.size() == 0 && done_due < 0)
        done_due = cyc + 1;
      chk("done", 32'(done), 32'(cyc == done_due));
      if (cyc == done_due) begin
        m_busy = 0; m_active = 0; pass_done = 1; done_cyc = cyc; done_due = -1;
      end
      chk("busy", 32'(busy), 32'(m_busy));
      chk("read_only_when_busy", 32'(mem_rd_en & ~m_busy), 32'd0);
      if (start && !m_active) begin
        m_active = 1; m_busy = 1; start_cyc = cyc;
        if (exp_if.size() == 0 && exp_f.size() == 0) done_due = cyc + 3;
      end
      prev_rd = mem_rd_en; prev_addr = mem_addr;
      iful_d2 = iful_d1; iful_d1 = ifmap_full;
      fful_d2 = fful_d1; fful_d1 = filter_full;
    end
  end

  task automatic start_pass(input logic [AW-1:0] ib, input logic [LW-1:0] il,
                            input logic [AW-1:0] fb, input logic [LW-1:0] fl);
    exp_if.delete(); exp_ia.delete(); exp_f.delete(); exp_fa.delete();
    log_if.delete(); log_f.delete(); log_sel.delete();
    for (int i = 0; i < int'(il); i++) begin
      logic [AW-1:0] a;
      a = ib + AW'(i);
      exp_if.push_back({i == 0, i == int'(il) - 1, mem[a]});
      exp_ia.push_back(a);
    end
    for (int i = 0; i < int'(fl); i++) begin
      logic [AW-1:0] a;
      a = fb + AW'(i);
      exp_f.push_back(mem[a]);
      exp_fa.push_back(a);
    end
    pass_done = 0;
    rd_cnt = 0;
    @(posedge clk); #1;
    ifmap_base = ib; ifmap_len = il; filter_base = fb; filter_len = fl;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!pass_done && n < 400) begin
      @(posedge clk);
      n++;
    end
    chk("pass_completes", 32'(pass_done), 32'd1);
    @(posedge clk); #1;
  endtask

  function automatic logic [DW+1:0] get_if(input int i);
    if (i < log_if.size()) return log_if[i];
    return '0;
  endfunction

  initial begin
    logic [DW+1:0] w;
    logic [8:0]    seq;
    int            iw, fw, n;

    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'(i * 40503 + 17);
    mem[10'h010] = 16'h3FD7;
    mem[10'h011] = 16'h0029;
    mem[10'h012] = 16'h3FD3;

    #1 rst_n = 1'b0;
    #2;
    chk("reset_state", 32'({mem_rd_en, ifmap_wr_en, filter_wr_en, busy, done,
                            mem_addr != '0, ifmap_wdata != '0, filter_wdata != '0}), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Three ifmap words, no filter.
    start_pass(10'h010, 8'd3, 10'h000, 8'd0);
    wait_done();
    chk("t1_ifmap_count", 32'(log_if.size()), 32'd3);
    chk("t1_word0", 32'(get_if(0)), 32'h23FD7);
    chk("t1_word1", 32'(get_if(1)), 32'h00029);
    chk("t1_word2", 32'(get_if(2)), 32'h13FD3);
    chk("t1_filter_count", 32'(log_f.size()), 32'd0);
    chk("t1_done_latency", 32'(done_cyc - start_cyc), 32'd8);

    // Interleaving: ifmap 2, filter 7.
    start_pass(10'h100, 8'd2, 10'h200, 8'd7);
    wait_done();
    seq = '0;
    foreach (log_sel[i]) seq = {seq[7:0], log_sel[i]};
    chk("t2_write_count", 32'(log_sel.size()), 32'd9);
    chk("t2_order", 32'(seq), 32'(9'b010111111));
    w = get_if(0);
    chk("t2_tags_first", 32'(w[DW+1:DW]), 32'd2);
    w = get_if(1);
    chk("t2_tags_second", 32'(w[DW+1:DW]), 32'd1);
    chk("t2_filter_count", 32'(log_f.size()), 32'd7);
    chk("t2_done_latency", 32'(done_cyc - start_cyc), 32'd17);

    // Filter buffer full for 5 cycles while a filter read is in flight;
    // filter addresses wrap past the top of memory.
    start_pass(10'h040, 8'd6, 10'h3FC, 8'd6);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t3_filter_read_inflight", 32'(mem_rd_en), 32'd1);
    chk("t3_filter_read_addr", 32'(mem_addr), 32'h3FC);
    filter_full = 1'b1;
    iw = 0; fw = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (k == 4) filter_full = 1'b0;
      @(negedge clk);
      iw += int'(ifmap_wr_en);
      fw += int'(filter_wr_en);
    end
    chk("t3_filter_writes_in_hold", 32'(fw), 32'd1);
    chk("t3_ifmap_writes_in_hold", 32'(iw), 32'd3);
    wait_done();
    chk("t3_ifmap_count", 32'(log_if.size()), 32'd6);
    chk("t3_filter_count", 32'(log_f.size()), 32'd6);

    // Both lengths zero.
    start_pass(10'h000, 8'd0, 10'h000, 8'd0);
    wait_done();
    chk("t4_no_reads", 32'(rd_cnt), 32'd0);
    chk("t4_done_latency", 32'(done_cyc - start_cyc), 32'd3);

    // Single ifmap word at the top address plus two filter words.
    start_pass(10'h3FF, 8'd1, 10'h000, 8'd2);
    wait_done();
    chk("t5_ifmap_count", 32'(log_if.size()), 32'd1);
    w = get_if(0);
    chk("t5_both_tags", 32'(w[DW+1:DW]), 32'd3);
    chk("t5_done_latency", 32'(done_cyc - start_cyc), 32'd7);

    // Reset in the middle of a pass, then restart.
    start_pass(10'h020, 8'd5, 10'h000, 8'd0);
    n = 0;
    while (log_if.size() < 2 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("t6_two_words_before_reset", 32'(log_if.size()), 32'd2);
    #3;
    chk("t6_read_before_reset", 32'(mem_rd_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_async_reset_outputs", 32'({mem_rd_en, ifmap_wr_en, filter_wr_en, busy, done,
                                       mem_addr != '0, ifmap_wdata != '0, filter_wdata != '0}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    chk("t6_no_done_after_reset", 32'(pass_done), 32'd0);
    chk("t6_no_writes_after_reset", 32'(log_if.size()), 32'd2);
    start_pass(10'h020, 8'd5, 10'h000, 8'd0);
    wait_done();
    chk("t6_restart_count", 32'(log_if.size()), 32'd5);
    chk("t6_restart_first", 32'(get_if(0)), 32'({2'b10, mem[10'h020]}));
    w = get_if(4);
    chk("t6_restart_last_tags", 32'(w[DW+1:DW]), 32'd1);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
